// File: rtl/uart_pulse_cmd_parser.sv
// Assembles 8-byte pulse command frames from the uart_rx byte stream. Each frame is
// checksum and range checked before the pulse parameters are loaded or fired.
module uart_pulse_cmd_parser #(
  parameter logic [7:0]      HEADER       = 8'h07,
  parameter logic [7:0]      CMD_FIRE     = 8'h01,
  parameter logic [7:0]      CMD_LOAD     = 8'h02,
  parameter int              TO_W         = 20,
  parameter logic [TO_W-1:0] TIMEOUT_CLKS = 20'd260_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] po_data,
  input  logic       po_flag,
  output logic [6:0] pulse_width1,
  output logic [6:0] pulse_width2,
  output logic [6:0] pulse_gap,
  output logic       cfg_valid,
  output logic       fire,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CLKS - 1'b1;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      buf_q [8];
  logic [7:0]      buf_d [8];
  logic [6:0]      pw1_q, pw1_d, pw2_q, pw2_d, gap_q, gap_d;
  logic            cfg_valid_q, cfg_valid_d, fire_q, fire_d, frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic [7:0] chk_sum;
  logic       cmd_ok;
  logic       range_bad;

  always_comb begin
    chk_sum = 8'd0;
    for (int i = 0; i < 7; i++) chk_sum = chk_sum + buf_q[i];
  end

  assign cmd_ok    = (buf_q[1] == CMD_FIRE) || (buf_q[1] == CMD_LOAD);
  assign range_bad = buf_q[3][7] | buf_q[4][7] | buf_q[5][7];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    to_cnt_d    = to_cnt_q;
    buf_d       = buf_q;
    pw1_d       = pw1_q;
    pw2_d       = pw2_q;
    gap_d       = gap_q;
    cfg_valid_d = 1'b0;
    fire_d      = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (po_flag && po_data == HEADER) begin
          buf_d[0] = po_data;
          idx_d    = 3'd1;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        // A byte arriving on the terminal count still counts as in time.
        if (po_flag) begin
          buf_d[idx_q] = po_data;
          idx_d        = idx_q + 3'd1;
          to_cnt_d     = '0;
          if (idx_q == 3'd7) state_d = CHECK;
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = IDLE;
          idx_d       = 3'd0;
          to_cnt_d    = '0;
          frame_err_d = 1'b1;
          err_code_d  = 2'b10;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d  = IDLE;
        idx_d    = 3'd0;
        to_cnt_d = '0;
        if (chk_sum != buf_q[7]) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'b01;
        end else if (!cmd_ok || range_bad) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'b11;
        end else begin
          pw1_d       = buf_q[3][6:0];
          pw2_d       = buf_q[4][6:0];
          gap_d       = buf_q[5][6:0];
          cfg_valid_d = 1'b1;
          fire_d      = (buf_q[1] == CMD_FIRE);
        end
        // Evaluation uses the registered buffer, so a header arriving now is safe to capture.
        if (po_flag && po_data == HEADER) begin
          buf_d[0] = po_data;
          idx_d    = 3'd1;
          state_d  = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      to_cnt_q    <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= 8'd0;
      pw1_q       <= 7'd0;
      pw2_q       <= 7'd0;
      gap_q       <= 7'd0;
      cfg_valid_q <= 1'b0;
      fire_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      to_cnt_q    <= to_cnt_d;
      buf_q       <= buf_d;
      pw1_q       <= pw1_d;
      pw2_q       <= pw2_d;
      gap_q       <= gap_d;
      cfg_valid_q <= cfg_valid_d;
      fire_q      <= fire_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign pulse_width1 = pw1_q;
  assign pulse_width2 = pw2_q;
  assign pulse_gap    = gap_q;
  assign cfg_valid    = cfg_valid_q;
  assign fire         = fire_q;
  assign frame_err    = frame_err_q;
  assign err_code     = err_code_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_pulse_cmd_parser.sv
// Directed frames for uart_pulse_cmd_parser; expected strobes are queued by the
// stimulus and checked, including their cycle of arrival, by a separate monitor.
module tb_uart_pulse_cmd_parser;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] po_data;
  logic       po_flag;
  logic [6:0] pulse_width1, pulse_width2, pulse_gap;
  logic       cfg_valid, fire, frame_err, busy;
  logic [1:0] err_code;

  uart_pulse_cmd_parser #(.TIMEOUT_CLKS(20'd64)) dut (
    .sys_clk(clk), .sys_rst(rst), .po_data(po_data), .po_flag(po_flag),
    .pulse_width1(pulse_width1), .pulse_width2(pulse_width2), .pulse_gap(pulse_gap),
    .cfg_valid(cfg_valid), .fire(fire), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       cfg, fr, err;
    logic [1:0] code;
    logic [6:0] w1, w2, g;
    int         at;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   last_k = 0;

  task automatic chk(input string name, input int got, input int want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic push_exp(input logic c, input logic f, input logic e, input logic [1:0] code,
                          input logic [6:0] w1, input logic [6:0] w2, input logic [6:0] g,
                          input int at);
    exp_t x;
    x.cfg = c; x.fr = f; x.err = e; x.code = code;
    x.w1 = w1; x.w2 = w2; x.g = g; x.at = at;
    q.push_back(x);
  endtask

  // Monitor: every strobe cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (cfg_valid || fire || frame_err)) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_strobe: cfg=%0b fire=%0b err=%0b at cycle %0d",
                 cfg_valid, fire, frame_err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("txn cyc=%0d cfg=%0b fire=%0b err=%0b code=%0d w1=%0d w2=%0d gap=%0d",
                 cyc, cfg_valid, fire, frame_err, err_code, pulse_width1, pulse_width2, pulse_gap);
        chk("strobes", {cfg_valid, fire, frame_err}, {e.cfg, e.fr, e.err});
        chk("err_code", err_code, e.code);
        chk("params", {pulse_width1, pulse_width2, pulse_gap}, {e.w1, e.w2, e.g});
        chk("latency", cyc, e.at);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    po_data = b;
    po_flag = 1'b1;
    last_k  = cyc;
    @(posedge clk); #1;
    po_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [63:0] fr, input int gap_idx, input int gap_len);
    for (int i = 0; i < 8; i++) begin
      send_byte(fr[63-8*i -: 8]);
      if (i == gap_idx) idle(gap_len);
    end
  endtask

  task automatic expect_frame(input logic c, input logic f, input logic e, input logic [1:0] code,
                              input logic [6:0] w1, input logic [6:0] w2, input logic [6:0] g);
    push_exp(c, f, e, code, w1, w2, g, last_k + 2);
  endtask

  localparam logic [63:0] FR_A     = 64'h07_01_00_0A_14_05_00_2B;
  localparam logic [63:0] FR_B     = 64'h07_02_00_03_04_02_00_12;
  localparam logic [63:0] FR_BADCK = 64'h07_01_00_0A_14_05_00_2C;
  localparam logic [63:0] FR_RANGE = 64'h07_01_00_80_01_01_00_8A;
  localparam logic [63:0] FR_UNK   = 64'h07_05_00_01_01_01_00_0F;
  localparam logic [63:0] FR_PRIO  = 64'h07_01_00_80_01_01_00_8B;
  localparam logic [63:0] FR_ZERO  = 64'h07_02_00_00_00_00_00_09;
  localparam logic [63:0] FR_MAX   = 64'h07_01_00_7F_7F_7F_00_85;

  initial begin
    rst = 1'b1; po_flag = 1'b0; po_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {pulse_width1, pulse_width2, pulse_gap, cfg_valid, fire, frame_err, err_code}, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    idle(2);

    send_frame(FR_A, -1, 0);      expect_frame(1, 1, 0, 2'b00, 10, 20, 5);
    idle(4);
    send_frame(FR_B, -1, 0);      expect_frame(1, 0, 0, 2'b00, 3, 4, 2);
    idle(4);
    send_frame(FR_BADCK, -1, 0);  expect_frame(0, 0, 1, 2'b01, 3, 4, 2);
    idle(4);
    send_byte(8'hFF); send_byte(8'h33);
    send_frame(FR_A, -1, 0);      expect_frame(1, 1, 0, 2'b01, 10, 20, 5);
    idle(4);
    send_frame(FR_RANGE, -1, 0);  expect_frame(0, 0, 1, 2'b11, 10, 20, 5);
    idle(4);
    send_frame(FR_UNK, -1, 0);    expect_frame(0, 0, 1, 2'b11, 10, 20, 5);
    idle(4);
    send_frame(FR_PRIO, -1, 0);   expect_frame(0, 0, 1, 2'b01, 10, 20, 5);
    idle(4);

    // Stalled partial frame
    send_byte(8'h07); send_byte(8'h01);
    chk("busy_collect", busy, 1);
    send_byte(8'h00);
    push_exp(0, 0, 1, 2'b10, 10, 20, 5, last_k + TO + 1);
    idle(TO + 4);
    chk("busy_after_timeout", busy, 0);
    send_frame(FR_B, -1, 0);      expect_frame(1, 0, 0, 2'b10, 3, 4, 2);
    idle(4);
    send_frame(FR_ZERO, -1, 0);   expect_frame(1, 0, 0, 2'b10, 0, 0, 0);
    idle(4);
    // Byte arrives exactly on the timeout terminal count
    send_frame(FR_MAX, 3, TO - 1); expect_frame(1, 1, 0, 2'b10, 127, 127, 127);
    idle(4);
    // Header of the second frame lands during CHECK of the first
    send_frame(FR_B, -1, 0);      expect_frame(1, 0, 0, 2'b10, 3, 4, 2);
    send_frame(FR_A, -1, 0);      expect_frame(1, 1, 0, 2'b10, 10, 20, 5);
    idle(4);

    send_byte(8'h07); send_byte(8'h01); send_byte(8'h00); send_byte(8'h0A); send_byte(8'h14);
    rst = 1'b1;
    #2;
    chk("midreset_params", {pulse_width1, pulse_width2, pulse_gap}, 0);
    chk("midreset_strobes_code", {cfg_valid, fire, frame_err, err_code}, 0);
    chk("midreset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    send_frame(FR_A, -1, 0);      expect_frame(1, 1, 0, 2'b00, 10, 20, 5);
    idle(10);

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_pulse_cmd_parser.md
Name: uart_pulse_cmd_parser

Overview:
Synchronous command-frame assembler between uart_rx and functionGenerate. It collects 8-byte frames from the po_data/po_flag byte stream, resynchronises on the header byte and discards stalled partial frames by timeout. It validates each frame with a checksum and a range check, then loads registered pulse parameters. For fire commands it issues a single-cycle trigger that drives uart_flag of functionGenerate. All logic runs on sys_clk; po_flag is not used as a clock.

Parameters:
HEADER, 8'h07, required value of byte 0
CMD_FIRE, 8'h01, byte 1 value: load parameters and fire
CMD_LOAD, 8'h02, byte 1 value: load parameters only
TO_W, 20, timeout counter width
TIMEOUT_CLKS, 20'd260_000, maximum idle sys_clk cycles between bytes inside a frame (about 5 byte times at 9600 baud, 50 MHz)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  asynchronous reset, active-high
po_data  in  8  received byte, valid when po_flag=1
po_flag  in  1  one-cycle byte strobe, sys_clk domain
pulse_width1  out  7  first pulse width, 10 ns units
pulse_width2  out  7  second pulse width, 10 ns units
pulse_gap  out  7  gap between pulses, 10 ns units
cfg_valid  out  1  one-cycle strobe: parameters updated
fire  out  1  one-cycle trigger to functionGenerate
frame_err  out  1  one-cycle strobe: frame rejected
err_code  out  2  cause of last error, held until next error: 01 checksum, 10 timeout, 11 range/unknown command
busy  out  1  high while in COLLECT or CHECK

Behaviour:
- Reset (async, sys_rst=1):
  - state=IDLE, byte index=0, timeout counter=0, byte buffer cleared.
  - All outputs 0.
  - Reset mid-frame discards the partial frame; no strobes are produced.
- Frame format, bytes 0..7:
  - HEADER, CMD, reserved, width1, width2, gap, reserved, CHK.
  - CHK = (sum of bytes 0..6) mod 256, 8-bit wrap.
- State IDLE:
  - po_flag with po_data==HEADER: store as byte 0, index=1, go to COLLECT.
  - Any other byte is silently dropped (header resync); no error.
- State COLLECT:
  - Each po_flag stores po_data at the current index, increments the index and clears the timeout counter.
  - When byte 7 is stored, go to CHECK.
  - Without po_flag, the timeout counter increments. At TIMEOUT_CLKS-1: go to IDLE, index=0, frame_err=1 for one cycle, err_code=10.
  - If po_flag and timeout terminal count occur in the same cycle, po_flag wins: the byte is stored and the counter is cleared.
- State CHECK (exactly one cycle, then IDLE):
  - Checks run in this priority order:
    1. Checksum mismatch: err_code=01.
    2. CMD not CMD_FIRE or CMD_LOAD, or any of bytes 3..5 with bit7=1: err_code=11.
    3. Otherwise the frame is valid.
  - Valid frame: pulse_width1/pulse_width2/pulse_gap <= bytes 3/4/5 [6:0]; cfg_valid=1.
  - Valid frame with CMD_FIRE: fire=1 as well.
  - Invalid frame: frame_err=1; parameter outputs hold their previous values.
- Latency:
  - byte-7 po_flag in cycle N → CHECK in cycle N+1 → outputs, cfg_valid, fire and frame_err change in cycle N+2.
  - Strobes are high for exactly one cycle.
- po_flag during CHECK: treated as an IDLE-state byte (header test) in that same cycle. It is not lost and does not disturb the evaluation.
- Parameter outputs are registered and stable between cfg_valid strobes. functionGenerate may sample them at fire.
- Zero-valued fields are legal and passed through unchanged.
- Back-to-back frames with no gap are supported at any byte rate that uart_rx can produce.
- busy=1 in COLLECT and CHECK, 0 in IDLE.

Test Plan:
- Valid fire: send 07 01 00 0A 14 05 00 2B → 2 cycles after the last strobe, pulse_width1=10, pulse_width2=20, pulse_gap=5; cfg_valid=1 and fire=1 for one cycle; frame_err=0.
- Load only: send 07 02 00 03 04 02 00 12 → outputs 3/4/2, cfg_valid=1, fire stays 0.
- Bad checksum: send 07 01 00 0A 14 05 00 2C → frame_err=1, err_code=01, outputs keep prior values, fire=0.
- Resync and range:
  - Send FF 33 then a valid frame → garbage dropped silently, frame accepted.
  - Send 07 01 00 80 01 01 00 8A → frame_err=1, err_code=11.
- Timeout: send 07 01 00, then idle 260_000 cycles → frame_err=1, err_code=10, busy=0. A following valid frame is accepted.
- Boundaries:
  - Assert sys_rst after byte 4 → all outputs 0, next full frame accepted normally.
  - Apply po_flag and timeout terminal count in the same cycle → byte stored, no error.
  - Apply a header po_flag during CHECK → next frame captured correctly.
